// File: rtl/tlul_ibex_arb_pkg.sv
// Host indices and source-tag helpers for the two-host Ibex TL-UL arbiter.
package tlul_ibex_arb_pkg;
  import tlul_pkg::*;

  typedef enum logic {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } host_e;

  localparam int NumHosts = 2;

  // The host index rides in the LSB of a_source so the D channel can be steered back.
  function automatic logic [TL_AIW-1:0] tag_source(logic [TL_AIW-1:0] src, host_e idx);
    return {src[TL_AIW-2:0], idx};
  endfunction

  function automatic logic [TL_AIW-1:0] untag_source(logic [TL_AIW-1:0] src);
    return {1'b0, src[TL_AIW-1:1]};
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types and idle defaults shared by the Ibex host ports and the SoC device port.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic                  a_valid;
    tl_a_op_e              a_opcode;
    logic [2:0]            a_param;
    logic [TL_SZW-1:0]     a_size;
    logic [TL_AIW-1:0]     a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DBW-1:0]     a_mask;
    logic [TL_DW-1:0]      a_data;
    tl_a_user_t            a_user;
    logic                  d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                  d_valid;
    tl_d_op_e              d_opcode;
    logic [2:0]            d_param;
    logic [TL_SZW-1:0]     d_size;
    logic [TL_AIW-1:0]     d_source;
    logic [TL_DIW-1:0]     d_sink;
    logic [TL_DW-1:0]      d_data;
    tl_d_user_t            d_user;
    logic                  d_error;
    logic                  a_ready;
  } tl_d2h_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '{d_ready: 1'b1, a_opcode: Get, default: '0};
  localparam tl_d2h_t TL_D2H_DEFAULT = '{a_ready: 1'b1, d_opcode: AccessAck, default: '0};

endpackage

// File: rtl/tlul_ibex_arb_if.sv
// One TL-UL link (request + response struct) with host- and device-side views.
interface tlul_ibex_arb_if;
  import tlul_pkg::*;

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  modport host   (output h2d, input  d2h);
  modport device (input  h2d, output d2h);

endinterface

// File: rtl/tlul_ibex_arb_cnt.sv
// Saturating up/down counter of unanswered A beats for one host.
module tlul_ibex_arb_cnt #(
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  logic [CntW-1:0] r_count;

  assign o_full  = (r_count == CntW'(MaxOutstanding));
  assign o_empty = (r_count == '0);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_count <= r_count + CntW'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_count <= r_count - CntW'(1);
    end
  end

endmodule

// File: rtl/tlul_ibex_arb.sv
// Round-robin merge of the Ibex instruction and data TL-UL hosts onto one device port,
// with source tagging for D routing and per-host outstanding limits.
module tlul_ibex_arb
  import tlul_pkg::*;
  import tlul_ibex_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_instr_h_i,
  output tl_d2h_t tl_instr_h_o,
  input  tl_h2d_t tl_data_h_i,
  output tl_d2h_t tl_data_h_o,
  output tl_h2d_t tl_dev_o,
  input  tl_d2h_t tl_dev_i,
  output logic    idle_o,
  output logic    rsp_err_o
);

  tl_h2d_t w_h2d [NumHosts];
  tl_d2h_t w_d2h [NumHosts];

  logic [NumHosts-1:0] w_full, w_empty, w_elig, w_a_hs, w_d_hs;

  logic  r_active;
  host_e r_rr;
  logic  r_lock;
  host_e r_lock_idx;

  logic  w_gnt_valid;
  host_e w_gnt_idx;
  host_e w_d_idx;
  logic  w_d_unexp;
  logic  w_dev_d_ready;

  assign w_h2d[HostInstr] = tl_instr_h_i;
  assign w_h2d[HostData]  = tl_data_h_i;
  assign tl_instr_h_o     = w_d2h[HostInstr];
  assign tl_data_h_o      = w_d2h[HostData];

  for (genvar h = 0; h < NumHosts; h++) begin : g_host
    assign w_elig[h] = w_h2d[h].a_valid && !w_full[h];
    assign w_a_hs[h] = w_d2h[h].a_ready;
    assign w_d_hs[h] = w_d2h[h].d_valid && w_h2d[h].d_ready;

    tlul_ibex_arb_cnt #(.MaxOutstanding(MaxOutstanding)) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_inc   (w_a_hs[h]),
      .i_dec   (w_d_hs[h]),
      .o_full  (w_full[h]),
      .o_empty (w_empty[h])
    );
  end

  // A locked beat bypasses the eligibility check: its counter slot was reserved at grant time.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_gnt_idx   = r_lock_idx;
    w_gnt_valid = 1'b0;
    if (r_lock) begin
      w_gnt_valid = w_h2d[r_lock_idx].a_valid;
    end else if (&w_elig) begin
      w_gnt_idx   = r_rr;
      w_gnt_valid = 1'b1;
    end else if (w_elig[HostInstr]) begin
      w_gnt_idx   = HostInstr;
      w_gnt_valid = 1'b1;
    end else if (w_elig[HostData]) begin
      w_gnt_idx   = HostData;
      w_gnt_valid = 1'b1;
    end
    w_gnt_valid = w_gnt_valid && r_active;
  end

  assign w_d_idx       = host_e'(tl_dev_i.d_source[0]);
  assign w_d_unexp     = tl_dev_i.d_valid && w_empty[w_d_idx];
  assign w_dev_d_ready = r_active && (w_d_unexp || w_h2d[w_d_idx].d_ready);

  always_comb begin
    tl_dev_o          = w_h2d[w_gnt_idx];
    tl_dev_o.a_valid  = w_gnt_valid;
    tl_dev_o.a_source = tag_source(w_h2d[w_gnt_idx].a_source, w_gnt_idx);
    tl_dev_o.d_ready  = w_dev_d_ready;
  end

  // Unexpected responses are drained silently; neither host sees them.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      w_d2h[h]          = tl_dev_i;
      w_d2h[h].d_source = untag_source(tl_dev_i.d_source);
      w_d2h[h].d_valid  = r_active && tl_dev_i.d_valid && !w_d_unexp && (w_d_idx == host_e'(h));
      w_d2h[h].a_ready  = w_gnt_valid && (w_gnt_idx == host_e'(h)) && tl_dev_i.a_ready;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active   <= 1'b0;
      r_rr       <= HostInstr;
      r_lock     <= 1'b0;
      r_lock_idx <= HostInstr;
    end else begin
      r_active <= 1'b1;
      r_lock   <= w_gnt_valid && !tl_dev_i.a_ready;
      if (w_gnt_valid) begin
        r_lock_idx <= w_gnt_idx;
      end
      if (w_gnt_valid && tl_dev_i.a_ready) begin
        r_rr <= (w_gnt_idx == HostInstr) ? HostData : HostInstr;
      end
    end
  end

  assign idle_o    = (&w_empty) && !tl_instr_h_i.a_valid && !tl_data_h_i.a_valid;
  assign rsp_err_o = r_active && w_d_unexp;

endmodule

// File: tb/tb_tlul_ibex_arb.sv
// Randomized scoreboard bench for tlul_ibex_arb: random hosts and an in-order device model
// feed expected beats into queues; a negedge monitor checks them and a rule-level arbiter model.
module tb_tlul_ibex_arb;
  import tlul_pkg::*;
  import tlul_ibex_arb_pkg::*;

  localparam int unsigned MAX_OUT  = 2;
  localparam int          N_CYCLES = 3000;

  typedef struct {
    logic [TL_AIW-1:0] source;
    logic [TL_DW-1:0]  data;
    logic              error;
  } d_exp_t;

  typedef struct {
    logic [TL_AIW-1:0] source;
    int                host;
    bit                stale;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle, rsp_err;

  tlul_ibex_arb_if instr_if ();
  tlul_ibex_arb_if data_if ();
  tlul_ibex_arb_if dev_if ();

  tl_h2d_t h_req [NumHosts];
  tl_d2h_t h_rsp [NumHosts];
  tl_d2h_t dev_rsp;

  assign instr_if.h2d = h_req[0];
  assign data_if.h2d  = h_req[1];
  assign h_rsp[0]     = instr_if.d2h;
  assign h_rsp[1]     = data_if.d2h;
  assign dev_if.d2h   = dev_rsp;

  tlul_ibex_arb #(.MaxOutstanding(MAX_OUT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_instr_h_i (instr_if.h2d),
    .tl_instr_h_o (instr_if.d2h),
    .tl_data_h_i  (data_if.h2d),
    .tl_data_h_o  (data_if.d2h),
    .tl_dev_o     (dev_if.h2d),
    .tl_dev_i     (dev_if.d2h),
    .idle_o       (idle),
    .rsp_err_o    (rsp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  tl_h2d_t exp_a_q [NumHosts][$];
  d_exp_t  exp_d_q [NumHosts][$];
  pend_t   pend [$];

  bit allow_new   = 1'b1;
  bit allow_stray = 1'b1;
  bit hold_d      = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pend_cnt(int h);
    int n = 0;
    foreach (pend[i]) if (pend[i].host == h) n++;
    return n;
  endfunction

  task automatic push_req(int h);
    tl_h2d_t e;
    e = h_req[h];
    e.a_source = TL_AIW'((int'(h_req[h].a_source) * 2) + h);
    exp_a_q[h].push_back(e);
  endtask

  task automatic new_req(int h);
    h_req[h].a_valid   = 1'b1;
    h_req[h].a_opcode  = ($urandom_range(0, 1) == 1) ? Get : PutFullData;
    h_req[h].a_param   = '0;
    h_req[h].a_size    = 2'd2;
    h_req[h].a_source  = TL_AIW'($urandom_range(0, 127));
    h_req[h].a_address = $urandom & 32'hFFFF_FFFC;
    h_req[h].a_mask    = 4'($urandom);
    h_req[h].a_data    = $urandom;
    h_req[h].a_user    = $bits(tl_a_user_t)'($urandom);
    push_req(h);
  endtask

  task automatic pick_rsp();
    int    r;
    int    sh;
    pend_t p;
    r  = $urandom_range(0, 99);
    sh = $urandom_range(0, 1);
    if (pend.size() > 0 && r < 50) begin
      p = pend.pop_front();
      dev_rsp.d_valid  = 1'b1;
      dev_rsp.d_opcode = AccessAckData;
      dev_rsp.d_size   = 2'd2;
      dev_rsp.d_source = p.source;
      dev_rsp.d_data   = $urandom;
      dev_rsp.d_user   = $bits(tl_d_user_t)'($urandom);
      dev_rsp.d_error  = ($urandom_range(0, 7) == 0);
      if (!p.stale)
        exp_d_q[p.host].push_back('{source: TL_AIW'(int'(p.source) / 2),
                                    data: dev_rsp.d_data, error: dev_rsp.d_error});
    end else if (allow_stray && r >= 95 && pend_cnt(sh) == 0) begin
      dev_rsp.d_valid  = 1'b1;
      dev_rsp.d_source = TL_AIW'(($urandom_range(0, 127) * 2) + sh);
      dev_rsp.d_data   = $urandom;
    end
  endtask

  // One clock: sample handshakes away from the edge, then drive the next cycle's inputs.
  task automatic step();
    bit                acc [NumHosts];
    bit                dev_a_hs, dev_d_hs;
    logic [TL_AIW-1:0] a_src;
    @(negedge clk);
    for (int h = 0; h < NumHosts; h++) acc[h] = h_req[h].a_valid && h_rsp[h].a_ready;
    dev_a_hs = dev_if.h2d.a_valid && dev_rsp.a_ready;
    a_src    = dev_if.h2d.a_source;
    dev_d_hs = dev_rsp.d_valid && dev_if.h2d.d_ready;
    @(posedge clk);
    #1;
    if (dev_a_hs) pend.push_back('{source: a_src, host: int'(a_src[0]), stale: 1'b0});
    for (int h = 0; h < NumHosts; h++) begin
      if (!h_req[h].a_valid || acc[h]) begin
        if (allow_new && $urandom_range(0, 99) < 60) new_req(h);
        else h_req[h].a_valid = 1'b0;
      end
      h_req[h].d_ready = ($urandom_range(0, 99) < 75);
    end
    dev_rsp.a_ready = ($urandom_range(0, 99) < 70);
    if (!dev_rsp.d_valid || dev_d_hs) begin
      dev_rsp.d_valid = 1'b0;
      if (!hold_d) pick_rsp();
    end
  endtask

  // Arbiter rules held as plain integers: pointer, lock, per-host unanswered counts.
  int m_rr, m_lock_idx;
  bit m_lock, m_active;
  int m_cnt [NumHosts];

  always @(negedge clk) begin : monitor
    bit      elig [NumHosts];
    bit      exp_av, unexp, exp_dv;
    int      win, tag, hh;
    tl_h2d_t ea;
    d_exp_t  ed;
    if (!rst_n) begin
      m_rr = 0; m_lock = 1'b0; m_lock_idx = 0; m_active = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      check("rst_dev_a_valid", dev_if.h2d.a_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
    end else begin
      for (int h = 0; h < NumHosts; h++) elig[h] = h_req[h].a_valid && (m_cnt[h] < MAX_OUT);
      win = 0;
      exp_av = 1'b0;
      if (!m_active) exp_av = 1'b0;
      else if (m_lock) begin win = m_lock_idx; exp_av = h_req[win].a_valid; end
      else if (elig[0] && elig[1]) begin win = m_rr; exp_av = 1'b1; end
      else if (elig[0]) begin win = 0; exp_av = 1'b1; end
      else if (elig[1]) begin win = 1; exp_av = 1'b1; end
      check("dev_a_valid", dev_if.h2d.a_valid, exp_av);
      if (exp_av) check("grant_idx", dev_if.h2d.a_source[0], win);
      for (int h = 0; h < NumHosts; h++)
        check($sformatf("host%0d_a_ready", h), h_rsp[h].a_ready,
              exp_av && (win == h) && dev_rsp.a_ready);

      if (dev_if.h2d.a_valid && dev_rsp.a_ready) begin
        hh = int'(dev_if.h2d.a_source[0]);
        if (exp_a_q[hh].size() == 0) check("a_sb_nonempty", exp_a_q[hh].size(), 1);
        else begin
          ea = exp_a_q[hh].pop_front();
          check("a_source", dev_if.h2d.a_source, ea.a_source);
          check("a_address", dev_if.h2d.a_address, ea.a_address);
          check("a_data", dev_if.h2d.a_data, ea.a_data);
          check("a_user", dev_if.h2d.a_user, ea.a_user);
          check("a_mask_op", {dev_if.h2d.a_mask, dev_if.h2d.a_opcode}, {ea.a_mask, ea.a_opcode});
        end
      end

      tag   = int'(dev_rsp.d_source[0]);
      unexp = dev_rsp.d_valid && (m_cnt[tag] == 0);
      for (int h = 0; h < NumHosts; h++)
        check($sformatf("host%0d_d_valid", h), h_rsp[h].d_valid,
              m_active && dev_rsp.d_valid && !unexp && (tag == h));
      check("dev_d_ready", dev_if.h2d.d_ready, m_active && (unexp || h_req[tag].d_ready));
      check("rsp_err", rsp_err, m_active && unexp);
      check("idle", idle, (m_cnt[0] == 0) && (m_cnt[1] == 0) &&
                          !h_req[0].a_valid && !h_req[1].a_valid);

      for (int h = 0; h < NumHosts; h++) begin
        if (h_rsp[h].d_valid && h_req[h].d_ready) begin
          if (exp_d_q[h].size() == 0) check("d_sb_nonempty", exp_d_q[h].size(), 1);
          else begin
            ed = exp_d_q[h].pop_front();
            check($sformatf("host%0d_d_source", h), h_rsp[h].d_source, ed.source);
            check($sformatf("host%0d_d_data", h), h_rsp[h].d_data, ed.data);
            check($sformatf("host%0d_d_error", h), h_rsp[h].d_error, ed.error);
          end
        end
      end

      if (exp_av && dev_rsp.a_ready) begin
        m_cnt[win]++;
        m_rr = 1 - win;
      end
      for (int h = 0; h < NumHosts; h++) begin
        exp_dv = m_active && dev_rsp.d_valid && !unexp && (tag == h);
        if (exp_dv && h_req[h].d_ready) m_cnt[h]--;
      end
      m_lock = exp_av && !dev_rsp.a_ready;
      if (exp_av) m_lock_idx = win;
      m_active = 1'b1;
    end
  end

  initial begin : stimulus
    bit ready_for_reset;
    bit drained;
    for (int h = 0; h < NumHosts; h++) h_req[h] = TL_H2D_DEFAULT;
    dev_rsp = TL_D2H_DEFAULT;
    // Both hosts waiting across reset release; instr fetch at 0x80, both with source 0.
    for (int h = 0; h < NumHosts; h++) begin
      h_req[h].a_valid   = 1'b1;
      h_req[h].a_size    = 2'd2;
      h_req[h].a_source  = '0;
      h_req[h].a_address = (h == 0) ? 32'h80 : 32'h1000_0040;
      h_req[h].a_data    = $urandom;
      h_req[h].a_mask    = 4'hF;
      push_req(h);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (N_CYCLES) step();

    // Park responses until each host has one beat in flight, then reset underneath them.
    hold_d = 1'b1;
    allow_stray = 1'b0;
    ready_for_reset = 1'b0;
    for (int i = 0; i < 300 && !ready_for_reset; i++) begin
      step();
      ready_for_reset = (pend_cnt(0) > 0) && (pend_cnt(1) > 0) && !dev_rsp.d_valid;
    end
    check("reset_prep_done", ready_for_reset, 1);

    rst_n = 1'b0;
    allow_new = 1'b0;
    for (int h = 0; h < NumHosts; h++) begin
      h_req[h].a_valid = 1'b0;
      exp_a_q[h].delete();
      exp_d_q[h].delete();
    end
    foreach (pend[i]) pend[i].stale = 1'b1;
    dev_rsp.d_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", idle, 1);

    // Responses issued before reset now have no owner and must be drained as errors.
    hold_d = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      step();
      drained = (pend.size() == 0) && !dev_rsp.d_valid;
    end
    check("stale_drain_done", drained, 1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
